// File: rtl/pipe_ctrl_pkg.sv
// Shared definitions for the pipeline controller: FSM state encoding and
// operand forward-select codes.
package pipe_ctrl_pkg;

   typedef enum logic [1:0] {
      ST_RUN    = 2'd0,
      ST_DRAIN  = 2'd1,
      ST_HALTED = 2'd2
   } state_e;

   localparam logic [1:0] FWD_REG    = 2'b00;
   localparam logic [1:0] FWD_EX_MEM = 2'b01;
   localparam logic [1:0] FWD_MEM_WB = 2'b10;

   // The youngest producer (EX) wins when both stages write the same register.
   function automatic logic [1:0] fwd_sel(input logic ex_m, input logic mem_m);
      if (ex_m)
         return FWD_EX_MEM;
      else if (mem_m)
         return FWD_MEM_WB;
      return FWD_REG;
   endfunction

endpackage

// File: rtl/pipe_ctrl_hazard_cmp.sv
// Compares one ID source operand against the EX and MEM destinations.
// Register 0 never matches.
module hazard_cmp #(
   parameter int RA_W = 5
) (
   input  logic [RA_W-1:0] i_rs,
   input  logic            i_use,
   input  logic [RA_W-1:0] i_ex_rd,
   input  logic            i_ex_wen,
   input  logic [RA_W-1:0] i_mem_rd,
   input  logic            i_mem_wen,
   output logic            o_ex_match,
   output logic            o_mem_match
);

   logic w_live;

   assign w_live      = i_use && (i_rs != '0);
   assign o_ex_match  = w_live && i_ex_wen  && (i_rs == i_ex_rd);
   assign o_mem_match = w_live && i_mem_wen && (i_rs == i_mem_rd);

endmodule

// File: rtl/pipe_ctrl.sv
// Pipeline hazard/branch/halt controller. Define FORWARD_EN to enable operand
// forwarding (stall only on load-use); otherwise any EX/MEM match stalls.
module pipe_ctrl
   import pipe_ctrl_pkg::*;
#(
   parameter int RA_W      = 5,
   parameter int DRAIN_CYC = 3
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic [RA_W-1:0] id_rs1,
   input  logic [RA_W-1:0] id_rs2,
   input  logic            id_use1,
   input  logic            id_use2,
   input  logic            id_halt,
   input  logic [RA_W-1:0] ex_rd,
   input  logic [RA_W-1:0] mem_rd,
   input  logic            ex_wen,
   input  logic            mem_wen,
   input  logic            ex_load,
   input  logic            ex_br_taken,
   output logic            pc_stall,
   output logic            ifid_stall,
   output logic            ifid_flush,
   output logic            idex_bubble,
   output logic            pc_sel,
   output logic [1:0]      fwd_a,
   output logic [1:0]      fwd_b,
   output logic [15:0]     stall_cnt,
   output logic            halt,
   output state_e          dbg_state
);

   localparam int CNT_W = (DRAIN_CYC > 1) ? $clog2(DRAIN_CYC) : 1;
   localparam logic [CNT_W-1:0] DRAIN_LAST = CNT_W'(DRAIN_CYC - 1);

   state_e           r_state;
   logic [CNT_W-1:0] r_drain_cnt;
   logic [15:0]      r_stall_cnt;
   logic             r_halt;

   logic       w_ex1, w_mem1, w_ex2, w_mem2;
   logic       w_hazard;
   logic       w_run_stall;
   logic [1:0] w_fwd_a, w_fwd_b;

   hazard_cmp #(.RA_W(RA_W)) u_cmp_rs1 (
      .i_rs(id_rs1), .i_use(id_use1),
      .i_ex_rd(ex_rd), .i_ex_wen(ex_wen),
      .i_mem_rd(mem_rd), .i_mem_wen(mem_wen),
      .o_ex_match(w_ex1), .o_mem_match(w_mem1)
   );

   hazard_cmp #(.RA_W(RA_W)) u_cmp_rs2 (
      .i_rs(id_rs2), .i_use(id_use2),
      .i_ex_rd(ex_rd), .i_ex_wen(ex_wen),
      .i_mem_rd(mem_rd), .i_mem_wen(mem_wen),
      .o_ex_match(w_ex2), .o_mem_match(w_mem2)
   );

`ifdef FORWARD_EN
   // A load's data is not available until MEM, so only load-use must wait.
   assign w_hazard = ex_load && (w_ex1 || w_ex2);
   assign w_fwd_a  = fwd_sel(w_ex1, w_mem1);
   assign w_fwd_b  = fwd_sel(w_ex2, w_mem2);
`else
   logic w_unused;
   assign w_unused = ex_load;
   assign w_hazard = w_ex1 || w_mem1 || w_ex2 || w_mem2;
   assign w_fwd_a  = FWD_REG;
   assign w_fwd_b  = FWD_REG;
`endif

   assign w_run_stall = w_hazard && !ex_br_taken;

   always_comb begin
      pc_stall    = 1'b0;
      ifid_stall  = 1'b0;
      ifid_flush  = 1'b0;
      idex_bubble = 1'b0;
      pc_sel      = 1'b0;
      fwd_a       = FWD_REG;
      fwd_b       = FWD_REG;
      if (rst_n) begin
         fwd_a = w_fwd_a;
         fwd_b = w_fwd_b;
         case (r_state)
            ST_RUN: begin
               if (ex_br_taken) begin
                  pc_sel      = 1'b1;
                  ifid_flush  = 1'b1;
                  idex_bubble = 1'b1;
               end else if (w_hazard) begin
                  pc_stall    = 1'b1;
                  ifid_stall  = 1'b1;
                  idex_bubble = 1'b1;
               end
            end
            default: begin
               pc_stall    = 1'b1;
               ifid_stall  = 1'b1;
               idex_bubble = 1'b1;
            end
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state     <= ST_RUN;
         r_drain_cnt <= '0;
         r_stall_cnt <= '0;
         r_halt      <= 1'b0;
      end else begin
         case (r_state)
            ST_RUN: begin
               if (w_run_stall && (r_stall_cnt != 16'hFFFF))
                  r_stall_cnt <= r_stall_cnt + 16'd1;
               if (id_halt && !w_hazard && !ex_br_taken) begin
                  r_state     <= ST_DRAIN;
                  r_drain_cnt <= '0;
               end
            end
            ST_DRAIN: begin
               if (r_drain_cnt == DRAIN_LAST) begin
                  r_state <= ST_HALTED;
                  r_halt  <= 1'b1;
               end else begin
                  r_drain_cnt <= r_drain_cnt + CNT_W'(1);
               end
            end
            ST_HALTED: r_halt <= 1'b1;
            default:   r_state <= ST_RUN;
         endcase
      end
   end

   assign stall_cnt = r_stall_cnt;
   assign halt      = r_halt;
   assign dbg_state = r_state;

endmodule

// File: tb/tb_pipe_ctrl.sv
// Randomized bench for pipe_ctrl with a rule-level reference model.
module tb_pipe_ctrl;
   import pipe_ctrl_pkg::*;

   localparam int RA_W      = 5;
   localparam int DRAIN_CYC = 3;

   logic            clk = 1'b0;
   logic            rst_n;
   logic [RA_W-1:0] id_rs1, id_rs2, ex_rd, mem_rd;
   logic            id_use1, id_use2, id_halt, ex_wen, mem_wen, ex_load, ex_br_taken;
   logic            pc_stall, ifid_stall, ifid_flush, idex_bubble, pc_sel, halt;
   logic [1:0]      fwd_a, fwd_b;
   logic [15:0]     stall_cnt;
   state_e          dbg_state;

   int n_vec = 0;
   int n_bad = 0;

   bit m_accepted;
   int m_since;
   int m_cnt;

   pipe_ctrl #(.RA_W(RA_W), .DRAIN_CYC(DRAIN_CYC)) dut (
      .clk(clk), .rst_n(rst_n),
      .id_rs1(id_rs1), .id_rs2(id_rs2), .id_use1(id_use1), .id_use2(id_use2),
      .id_halt(id_halt), .ex_rd(ex_rd), .mem_rd(mem_rd), .ex_wen(ex_wen),
      .mem_wen(mem_wen), .ex_load(ex_load), .ex_br_taken(ex_br_taken),
      .pc_stall(pc_stall), .ifid_stall(ifid_stall), .ifid_flush(ifid_flush),
      .idex_bubble(idex_bubble), .pc_sel(pc_sel), .fwd_a(fwd_a), .fwd_b(fwd_b),
      .stall_cnt(stall_cnt), .halt(halt), .dbg_state(dbg_state)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   function automatic bit src_hit(input bit u, input logic [RA_W-1:0] rs,
                                  input logic [RA_W-1:0] rd, input bit wen);
      return u && (rs != 0) && (rs == rd) && wen;
   endfunction

   // 0 = running, 1 = draining, 2 = halted
   function automatic int model_mode();
      if (!m_accepted) return 0;
      return (m_since < DRAIN_CYC) ? 1 : 2;
   endfunction

   function automatic bit model_stall_cond();
      bit e1, m1, e2, m2;
      e1 = src_hit(id_use1, id_rs1, ex_rd, ex_wen);
      m1 = src_hit(id_use1, id_rs1, mem_rd, mem_wen);
      e2 = src_hit(id_use2, id_rs2, ex_rd, ex_wen);
      m2 = src_hit(id_use2, id_rs2, mem_rd, mem_wen);
`ifdef FORWARD_EN
      return ex_load && (e1 || e2);
`else
      return e1 || m1 || e2 || m2;
`endif
   endfunction

   function automatic int model_fwd(input bit u, input logic [RA_W-1:0] rs);
`ifdef FORWARD_EN
      if (src_hit(u, rs, ex_rd, ex_wen)) return 1;
      if (src_hit(u, rs, mem_rd, mem_wen)) return 2;
`endif
      return 0;
   endfunction

   task automatic check_outputs();
      int mode;
      bit e_stall, e_flush, e_bub, e_sel;
      mode = model_mode();
      e_stall = 0; e_flush = 0; e_bub = 0; e_sel = 0;
      if (mode == 0) begin
         if (ex_br_taken) begin
            e_sel = 1; e_flush = 1; e_bub = 1;
         end else if (model_stall_cond()) begin
            e_stall = 1; e_bub = 1;
         end
      end else begin
         e_stall = 1; e_bub = 1;
      end
      chk("pc_stall", 32'(pc_stall), 32'(e_stall));
      chk("ifid_stall", 32'(ifid_stall), 32'(e_stall));
      chk("ifid_flush", 32'(ifid_flush), 32'(e_flush));
      chk("idex_bubble", 32'(idex_bubble), 32'(e_bub));
      chk("pc_sel", 32'(pc_sel), 32'(e_sel));
      chk("fwd_a", 32'(fwd_a), 32'(model_fwd(id_use1, id_rs1)));
      chk("fwd_b", 32'(fwd_b), 32'(model_fwd(id_use2, id_rs2)));
      chk("stall_cnt", 32'(stall_cnt), 32'(m_cnt));
      chk("halt", 32'(halt), 32'(mode == 2));
      chk("state", 32'(dbg_state),
          32'((mode == 0) ? ST_RUN : (mode == 1) ? ST_DRAIN : ST_HALTED));
   endtask

   task automatic model_edge();
      bit sc;
      sc = model_stall_cond();
      if (model_mode() == 0) begin
         if (sc && !ex_br_taken && m_cnt < 16'hFFFF) m_cnt++;
         if (id_halt && !sc && !ex_br_taken) begin
            m_accepted = 1;
            m_since    = 0;
         end
      end else if (m_since < DRAIN_CYC) begin
         m_since++;
      end
   endtask

   task automatic step(input logic [RA_W-1:0] rs1, input logic [RA_W-1:0] rs2,
                       input logic u1, input logic u2, input logic h,
                       input logic [RA_W-1:0] erd, input logic [RA_W-1:0] mrd,
                       input logic ew, input logic mw, input logic ld, input logic br);
      id_rs1 = rs1; id_rs2 = rs2; id_use1 = u1; id_use2 = u2; id_halt = h;
      ex_rd = erd; mem_rd = mrd; ex_wen = ew; mem_wen = mw; ex_load = ld; ex_br_taken = br;
      #3;
      check_outputs();
      @(posedge clk);
      model_edge();
      #1;
   endtask

   task automatic rand_step();
      step(RA_W'($urandom_range(0, 7)), RA_W'($urandom_range(0, 7)),
           1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
           1'($urandom_range(0, 39) == 0),
           RA_W'($urandom_range(0, 7)), RA_W'($urandom_range(0, 7)),
           1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
           1'($urandom_range(0, 1)), 1'($urandom_range(0, 7) == 0));
   endtask

   // Asserts reset mid-cycle so the asynchronous clear is visible before any edge.
   task automatic do_reset();
      id_use1 = 1; id_rs1 = 3; ex_rd = 3; ex_wen = 1; ex_br_taken = 1; ex_load = 1;
      rst_n = 1'b0;
      #1;
      m_accepted = 0; m_since = 0; m_cnt = 0;
      chk("rst_pc_stall", 32'(pc_stall), 32'd0);
      chk("rst_ifid_stall", 32'(ifid_stall), 32'd0);
      chk("rst_ifid_flush", 32'(ifid_flush), 32'd0);
      chk("rst_idex_bubble", 32'(idex_bubble), 32'd0);
      chk("rst_pc_sel", 32'(pc_sel), 32'd0);
      chk("rst_fwd_a", 32'(fwd_a), 32'd0);
      chk("rst_fwd_b", 32'(fwd_b), 32'd0);
      chk("rst_stall_cnt", 32'(stall_cnt), 32'd0);
      chk("rst_halt", 32'(halt), 32'd0);
      chk("rst_state", 32'(dbg_state), 32'(ST_RUN));
      @(posedge clk);
      #1;
      rst_n = 1'b1;
   endtask

   initial begin
      int lat;
      id_rs1 = '0; id_rs2 = '0; id_use1 = 0; id_use2 = 0; id_halt = 0;
      ex_rd = '0; mem_rd = '0; ex_wen = 0; mem_wen = 0; ex_load = 0; ex_br_taken = 0;
      rst_n = 1'b0;
      #2;
      do_reset();

      // EX producer feeding rs1 (forward or stall depending on build)
      step(5'd3, 5'd0, 1, 0, 0, 5'd3, 5'd0, 1, 0, 0, 0);

      // load-use on rs2: exactly one stall cycle counted
      do_reset();
      step(5'd0, 5'd5, 0, 1, 0, 5'd5, 5'd0, 1, 0, 1, 0);
      step(5'd0, 5'd0, 0, 0, 0, 5'd0, 5'd0, 0, 0, 0, 0);
      chk("loaduse_cnt", 32'(stall_cnt), 32'd1);

      // MEM match held for several cycles, then register 0
      repeat (3) step(5'd7, 5'd0, 1, 0, 0, 5'd0, 5'd7, 0, 1, 0, 0);
      step(5'd0, 5'd0, 1, 1, 0, 5'd0, 5'd0, 1, 1, 1, 0);

      // branch and load-use hazard in the same cycle
      step(5'd3, 5'd0, 1, 0, 0, 5'd3, 5'd0, 1, 0, 1, 1);

      // halt latency, with a stray branch in the first drain cycle
      do_reset();
      step(5'd0, 5'd0, 0, 0, 1, 5'd0, 5'd0, 0, 0, 0, 0);
      lat = 0;
      while (!halt && lat < 20) begin
         step(5'd3, 5'd3, 1, 1, 0, 5'd3, 5'd3, 1, 1, 1, 1'(lat == 0));
         lat++;
      end
      chk("halt_latency", 32'(lat), 32'(DRAIN_CYC));
      repeat (3) rand_step();

      // reset in the middle of a drain
      do_reset();
      step(5'd0, 5'd0, 0, 0, 1, 5'd0, 5'd0, 0, 0, 0, 0);
      step(5'd0, 5'd0, 0, 0, 0, 5'd0, 5'd0, 0, 0, 0, 0);
      #2;
      do_reset();

      for (int i = 0; i < 600; i++) begin
         rand_step();
         if (m_accepted && m_since >= DRAIN_CYC && $urandom_range(0, 3) == 0) begin
            #2;
            do_reset();
         end
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
